// File: rtl/amm_arb_pkg.sv
// Shared types and sizing helpers for the Avalon-MM round-robin arbiter.
package amm_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index width for n masters, never narrower than one bit.
  function automatic int amm_idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/amm_if.sv
// Avalon-MM bundle; master modport drives the command, slave modport answers it.
interface amm_if #(
  parameter int P_ASIZE  = 32,
  parameter int P_DBYTES = 4
);
  logic [P_ASIZE-1:0]    address;
  logic [8*P_DBYTES-1:0] writedata;
  logic [8*P_DBYTES-1:0] readdata;
  logic [P_DBYTES-1:0]   byteenable;
  logic                  read;
  logic                  write;
  logic                  waitrequest;

  modport master (output address, writedata, byteenable, read, write,
                  input  readdata, waitrequest);
  modport slave  (input  address, writedata, byteenable, read, write,
                  output readdata, waitrequest);
endinterface

// File: rtl/amm_rr_arbiter.sv
// Combinational rotate-priority pick: first requester after i_last_grant wins.
module amm_rr_arbiter
  import amm_arb_pkg::*;
#(
  parameter int P_NUM_MASTERS = 2,
  parameter int P_IDXW        = amm_idx_width(P_NUM_MASTERS)
) (
  input  logic [P_NUM_MASTERS-1:0] i_req,
  input  logic [P_IDXW-1:0]        i_last_grant,
  output logic [P_NUM_MASTERS-1:0] o_grant,
  output logic [P_IDXW-1:0]        o_idx
);

  logic [P_IDXW-1:0] w_cand;
  logic              w_found;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = i_last_grant;
    for (int k = 0; k < P_NUM_MASTERS; k++) begin
      w_cand = (w_cand == P_IDXW'(P_NUM_MASTERS - 1)) ? '0 : w_cand + P_IDXW'(1);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/amm_arbiter.sv
// N-to-1 Avalon-MM arbiter: one idle arbitration cycle, then the owner is
// connected straight through until its transfer completes.
module amm_arbiter
  import amm_arb_pkg::*;
#(
  parameter int P_NUM_MASTERS = 2,
  parameter int P_ASIZE       = 32,
  parameter int P_DBYTES      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  amm_if.slave                     s [P_NUM_MASTERS-1:0],
  amm_if.master                    m,
  output logic [P_NUM_MASTERS-1:0] grant
);

  localparam int IDXW = amm_idx_width(P_NUM_MASTERS);
  localparam int DW   = 8 * P_DBYTES;

  arb_state_e                r_state;
  logic [P_NUM_MASTERS-1:0]  r_grant;
  logic [IDXW-1:0]           r_grant_idx;
  logic [IDXW-1:0]           r_last_grant;

  logic [P_NUM_MASTERS-1:0]  w_req;
  logic [P_NUM_MASTERS-1:0]  w_pick;
  logic [IDXW-1:0]           w_pick_idx;
  logic                      w_busy;
  logic [P_ASIZE-1:0]        w_s_address    [P_NUM_MASTERS];
  logic [DW-1:0]             w_s_writedata  [P_NUM_MASTERS];
  logic [P_DBYTES-1:0]       w_s_byteenable [P_NUM_MASTERS];
  logic [P_NUM_MASTERS-1:0]  w_s_read;
  logic [P_NUM_MASTERS-1:0]  w_s_write;
  logic [P_ASIZE-1:0]        w_m_address;
  logic [DW-1:0]             w_m_writedata;
  logic [P_DBYTES-1:0]       w_m_byteenable;
  logic                      w_m_read;
  logic                      w_m_write;

  for (genvar g = 0; g < P_NUM_MASTERS; g++) begin : g_up
    assign w_s_address[g]    = s[g].address;
    assign w_s_writedata[g]  = s[g].writedata;
    assign w_s_byteenable[g] = s[g].byteenable;
    assign w_s_read[g]       = s[g].read;
    assign w_s_write[g]      = s[g].write;
    assign w_req[g]          = s[g].read | s[g].write;
    assign s[g].readdata     = m.readdata;
    // Only the owner may see the slave's waitrequest; everyone else is stalled.
    assign s[g].waitrequest  = ~(w_busy & r_grant[g]) | m.waitrequest;
  end

  assign w_busy = (r_state == BUSY);
  assign grant  = r_grant;

  amm_rr_arbiter #(
    .P_NUM_MASTERS (P_NUM_MASTERS),
    .P_IDXW        (IDXW)
  ) u_rr (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick),
    .o_idx        (w_pick_idx)
  );

  always_comb begin
    w_m_address    = '0;
    w_m_writedata  = '0;
    w_m_byteenable = '0;
    w_m_read       = 1'b0;
    w_m_write      = 1'b0;
    for (int i = 0; i < P_NUM_MASTERS; i++) begin
      if (w_busy && r_grant[i]) begin
        w_m_address    = w_s_address[i];
        w_m_writedata  = w_s_writedata[i];
        w_m_byteenable = w_s_byteenable[i];
        w_m_read       = w_s_read[i];
        w_m_write      = w_s_write[i];
      end
    end
  end

  assign m.address    = w_m_address;
  assign m.writedata  = w_m_writedata;
  assign m.byteenable = w_m_byteenable;
  assign m.read       = w_m_read;
  assign m.write      = w_m_write;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values; the async reset clears grant at once, which drops m.read/m.write mid-transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_grant_idx  <= '0;
      r_last_grant <= IDXW'(P_NUM_MASTERS - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_state     <= BUSY;
            r_grant     <= w_pick;
            r_grant_idx <= w_pick_idx;
          end
        end
        BUSY: begin
          if (!(w_m_read || w_m_write)) begin
            // Owner dropped its request: release without crediting it.
            r_state <= IDLE;
            r_grant <= '0;
          end else if (!m.waitrequest) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= r_grant_idx;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amm_arbiter.sv
// Directed bench for amm_arbiter: a 2-master instance for the main scenarios
// and a 4-master instance for round-robin wrap.
module tb_amm_arbiter;

  localparam int AW = 32;
  localparam int DB = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 2-master instance
  logic [1:0]    u2_read, u2_write, u2_wait;
  logic [AW-1:0] u2_addr  [2];
  logic [DW-1:0] u2_wdata [2];
  logic [DW-1:0] u2_rdata [2];
  logic [DB-1:0] u2_be    [2];
  logic          d2_read, d2_write, d2_wait;
  logic [AW-1:0] d2_addr;
  logic [DW-1:0] d2_wdata, d2_rdata;
  logic [DB-1:0] d2_be;
  logic [1:0]    grant2;

  amm_if #(.P_ASIZE(AW), .P_DBYTES(DB)) s2 [1:0] ();
  amm_if #(.P_ASIZE(AW), .P_DBYTES(DB)) m2 ();

  for (genvar g = 0; g < 2; g++) begin : g_up2
    assign s2[g].read       = u2_read[g];
    assign s2[g].write      = u2_write[g];
    assign s2[g].address    = u2_addr[g];
    assign s2[g].writedata  = u2_wdata[g];
    assign s2[g].byteenable = u2_be[g];
    assign u2_wait[g]       = s2[g].waitrequest;
    assign u2_rdata[g]      = s2[g].readdata;
  end
  assign d2_read        = m2.read;
  assign d2_write       = m2.write;
  assign d2_addr        = m2.address;
  assign d2_wdata       = m2.writedata;
  assign d2_be          = m2.byteenable;
  assign m2.waitrequest = d2_wait;
  assign m2.readdata    = d2_rdata;

  amm_arbiter #(.P_NUM_MASTERS(2), .P_ASIZE(AW), .P_DBYTES(DB)) dut2 (
    .clk(clk), .rst(rst), .s(s2), .m(m2), .grant(grant2)
  );

  // 4-master instance
  logic [3:0] u4_read, u4_wait, grant4;
  logic       d4_wait, d4_read;

  amm_if #(.P_ASIZE(AW), .P_DBYTES(DB)) s4 [3:0] ();
  amm_if #(.P_ASIZE(AW), .P_DBYTES(DB)) m4 ();

  for (genvar g = 0; g < 4; g++) begin : g_up4
    assign s4[g].read       = u4_read[g];
    assign s4[g].write      = 1'b0;
    assign s4[g].address    = AW'(g);
    assign s4[g].writedata  = '0;
    assign s4[g].byteenable = '0;
    assign u4_wait[g]       = s4[g].waitrequest;
  end
  assign d4_read        = m4.read;
  assign m4.waitrequest = d4_wait;
  assign m4.readdata    = '0;

  amm_arbiter #(.P_NUM_MASTERS(4), .P_ASIZE(AW), .P_DBYTES(DB)) dut4 (
    .clk(clk), .rst(rst), .s(s4), .m(m4), .grant(grant4)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]    exp_g;
    logic [1:0]    exp_w;
    logic [AW-1:0] exp_a;

    u2_read = '0; u2_write = '0;
    for (int i = 0; i < 2; i++) begin
      u2_addr[i] = '0; u2_wdata[i] = '0; u2_be[i] = '0;
    end
    d2_wait = 1'b0; d2_rdata = '0;
    u4_read = '0; d4_wait = 1'b0;

    // Reset held, then released
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant2", grant2, 2'b00);
    check("rst_wait2", u2_wait, 2'b11);
    check("rst_grant4", grant4, 4'b0000);
    @(negedge clk) rst = 1'b0;
    step();
    check("idle_grant", grant2, 2'b00);
    check("idle_mread", d2_read, 1'b0);
    check("idle_mwrite", d2_write, 1'b0);
    check("idle_maddr", d2_addr, 32'h0);
    check("idle_wait", u2_wait, 2'b11);
    check("idle_mread4", d4_read, 1'b0);
    check("idle_wait4", u4_wait, 4'b1111);

    // Single write from master 0, zero-wait slave
    u2_write[0] = 1'b1; u2_addr[0] = 32'h10; u2_wdata[0] = 32'hA5A5_A5A5; u2_be[0] = 4'hF;
    d2_wait = 1'b0;
    #1;
    check("A_arb_wait", u2_wait[0], 1'b1);
    check("A_arb_mwrite", d2_write, 1'b0);
    step();
    check("A_grant", grant2, 2'b01);
    check("A_mwrite", d2_write, 1'b1);
    check("A_maddr", d2_addr, 32'h10);
    check("A_mdata", d2_wdata, 32'hA5A5_A5A5);
    check("A_mbe", d2_be, 4'hF);
    check("A_wait", u2_wait, 2'b10);
    step();
    u2_write[0] = 1'b0;
    #1;
    check("A_done_grant", grant2, 2'b00);
    check("A_done_mwrite", d2_write, 1'b0);

    // Fresh reset, then both masters read continuously: 01,idle,10,idle,...
    rst = 1'b1; #1; rst = 1'b0;
    u2_addr[0] = 32'h100; u2_addr[1] = 32'h200; u2_read = 2'b11;
    for (int k = 0; k < 6; k++) begin
      step();
      exp_g = (k % 2 == 1) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10);
      exp_w = ~exp_g;
      check($sformatf("B_grant%0d", k), grant2, exp_g);
      check($sformatf("B_wait%0d", k), u2_wait, exp_w);
      if (exp_g != 2'b00) begin
        exp_a = (exp_g == 2'b01) ? 32'h100 : 32'h200;
        check($sformatf("B_maddr%0d", k), d2_addr, exp_a);
        check($sformatf("B_mread%0d", k), d2_read, 1'b1);
      end
    end
    u2_read = 2'b00;

    // Master 1 reads against three slave wait cycles; master 0 joins and stalls
    u2_addr[1] = 32'h300; u2_read[1] = 1'b1; d2_wait = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) u2_read[0] = 1'b1;
      if (c == 4) begin
        d2_wait = 1'b0; d2_rdata = 32'h1234_5678;
      end
      #1;
      check($sformatf("C_grant%0d", c), grant2, 2'b10);
      check($sformatf("C_s0wait%0d", c), u2_wait[0], 1'b1);
      check($sformatf("C_s1wait%0d", c), u2_wait[1], (c == 4) ? 1'b0 : 1'b1);
    end
    check("C_maddr", d2_addr, 32'h300);
    check("C_rdata1", u2_rdata[1], 32'h1234_5678);
    check("C_rdata0", u2_rdata[0], 32'h1234_5678);
    step();
    u2_read[1] = 1'b0;
    #1;
    check("C_idle", grant2, 2'b00);
    step();
    check("C_s0_served", grant2, 2'b01);
    check("C_s0_addr", d2_addr, 32'h100);
    step();
    u2_read[0] = 1'b0; d2_rdata = '0;
    #1;
    check("C_done", grant2, 2'b00);

    // Reset in the second BUSY cycle of a stalled write from master 1
    u2_write[1] = 1'b1; u2_addr[1] = 32'h400; d2_wait = 1'b1;
    step();
    check("D_grant", grant2, 2'b10);
    check("D_mwrite_busy", d2_write, 1'b1);
    step();
    rst = 1'b1;
    #1;
    check("D_rst_mwrite", d2_write, 1'b0);
    check("D_rst_grant", grant2, 2'b00);
    check("D_rst_wait", u2_wait, 2'b11);
    u2_write[0] = 1'b1;
    @(negedge clk) rst = 1'b0;
    step();
    check("D_first_after_rst", grant2, 2'b01);

    // Owner drops its request: back to IDLE with last_grant untouched
    u2_write = 2'b00; d2_wait = 1'b0;
    #1;
    check("V_mwrite", d2_write, 1'b0);
    step();
    check("V_idle", grant2, 2'b00);
    u2_read = 2'b11;
    step();
    check("V_rr_kept", grant2, 2'b01);
    step();
    u2_read = 2'b00;
    #1;
    check("V_done", grant2, 2'b00);

    // Four masters: serve 3, then requests on 0 and 2 wrap to 0, then 2
    u4_read = 4'b1000; d4_wait = 1'b0;
    step();
    check("E_grant3", grant4, 4'b1000);
    check("E_wait3", u4_wait, 4'b0111);
    step();
    u4_read = 4'b0101;
    #1;
    check("E_idle", grant4, 4'b0000);
    step();
    check("E_wrap0", grant4, 4'b0001);
    check("E_mread", d4_read, 1'b1);
    step();
    step();
    check("E_next2", grant4, 4'b0100);
    step();
    u4_read = 4'b0000;
    #1;
    check("E_done", grant4, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
